// File: rtl/transmit_comm.sv
// rtl/transmit_comm.sv - serial character transmitter: start bit, 8 data bits MSB first, stop bit
// Each frame bit is held for SAMPLES_PER_BIT clocks; serial_out is the MSB of the frame register.
module transmit_comm #(
  parameter int SAMPLES_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] parallel_in,
  input  logic       load,
  output logic       serial_out,
  output logic       tx_busy,
  output logic       char_sent
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  localparam logic [3:0] LP_BSC_LAST = 4'(SAMPLES_PER_BIT - 1);
  localparam logic [3:0] LP_BIC_LAST = 4'd9;

  state_t     r_state;
  logic [9:0] r_frame;
  logic [3:0] r_bsc;
  logic [3:0] r_bic;
  logic       r_busy;
  logic       r_sent;

  logic w_bit_end;
  assign w_bit_end = (r_bsc == LP_BSC_LAST);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_frame <= '1;
      r_bsc   <= '0;
      r_bic   <= '0;
      r_busy  <= 1'b0;
      r_sent  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          r_sent <= 1'b0;
          if (load) begin
            r_state <= SEND;
            r_frame <= {1'b0, parallel_in, 1'b1};
            r_bsc   <= '0;
            r_bic   <= '0;
            r_busy  <= 1'b1;
          end else begin
            r_state <= IDLE;
            r_frame <= '1;
            r_busy  <= 1'b0;
          end
        end
        SEND: begin
          if (w_bit_end) begin
            r_bsc <= '0;
            // Stop bit just finished: park the line high for the DONE cycle.
            if (r_bic == LP_BIC_LAST) begin
              r_state <= DONE;
              r_frame <= '1;
              r_busy  <= 1'b0;
              r_sent  <= 1'b1;
            end else begin
              r_bic   <= r_bic + 4'd1;
              r_frame <= {r_frame[8:0], 1'b1};
            end
          end else begin
            r_bsc <= r_bsc + 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_frame <= '1;
          r_busy  <= 1'b0;
          r_sent  <= 1'b0;
        end
      endcase
    end
  end

  assign serial_out = r_frame[9];
  assign tx_busy    = r_busy;
  assign char_sent  = r_sent;

endmodule

// File: tb/tb_transmit_comm.sv
// tb/tb_transmit_comm.sv - scoreboard bench for transmit_comm
// Stimulus pushes expected bytes; per-DUT monitors decode the line and compare.
module tb_transmit_comm;

  typedef struct packed {
    logic       abort;
    logic [7:0] d;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] pin16 = 8'h00;
  logic       load16 = 1'b0;
  logic       so16, busy16, cs16;
  logic [7:0] pin4 = 8'h00;
  logic       load4 = 1'b0;
  logic       so4, busy4, cs4;

  exp_t q16[$];
  exp_t q4[$];
  int   checks = 0;
  int   errors = 0;
  int   pulses16 = 0;
  int   pulses4 = 0;

  always #5 clk = ~clk;

  transmit_comm dut16 (
    .clk(clk), .reset(reset), .parallel_in(pin16), .load(load16),
    .serial_out(so16), .tx_busy(busy16), .char_sent(cs16)
  );

  transmit_comm #(.SAMPLES_PER_BIT(4)) dut4 (
    .clk(clk), .reset(reset), .parallel_in(pin4), .load(load4),
    .serial_out(so4), .tx_busy(busy4), .char_sent(cs4)
  );

  function automatic logic so(input int w);
    return (w == 0) ? so16 : so4;
  endfunction
  function automatic logic busy(input int w);
    return (w == 0) ? busy16 : busy4;
  endfunction
  function automatic logic cs(input int w);
    return (w == 0) ? cs16 : cs4;
  endfunction

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts negedges from the current point until char_sent is seen.
  task automatic wait_sent(input int w, output int n);
    bit seen;
    seen = 0;
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (cs(w)) begin
        seen = 1;
        break;
      end
    end
    if (!seen) chk(0, "char_sent_timeout", n, 0);
  endtask

  task automatic monitor(input int w);
    int         spb;
    int         bad;
    bit         ab;
    exp_t       e;
    logic [9:0] fb;
    logic [7:0] rx;
    spb = (w == 0) ? 16 : 4;
    forever begin
      @(negedge clk);
      if (reset && so(w) == 1'b0) begin
        if (((w == 0) ? q16.size() : q4.size()) == 0) begin
          chk(0, "unexpected_frame", w, 0);
          for (int i = 0; i < 200 && so(w) == 1'b0; i++) @(negedge clk);
        end else begin
          e  = (w == 0) ? q16.pop_front() : q4.pop_front();
          fb = {1'b0, e.d, 1'b1};
          bad = 0;
          ab  = 0;
          rx  = '0;
          for (int n = 0; n < 10 * spb; n++) begin
            if (n != 0) @(negedge clk);
            if (!reset) begin
              ab = 1;
              break;
            end
            if (so(w) !== fb[9 - n / spb] || busy(w) !== 1'b1 || cs(w) !== 1'b0) bad++;
            if (n % spb == spb / 2 && n / spb >= 1 && n / spb <= 8) rx = {rx[6:0], so(w)};
          end
          if (ab) begin
            chk(e.abort == 1'b1, "abort_expected", 1, int'(e.abort));
          end else begin
            chk(e.abort == 1'b0, "frame_completed", 0, int'(e.abort));
            chk(bad == 0, "frame_shape", bad, 0);
            chk(rx == e.d, "rx_byte", int'(rx), int'(e.d));
            @(negedge clk);
            chk({cs(w), busy(w), so(w)} == 3'b101, "done_cycle",
                int'({cs(w), busy(w), so(w)}), 3'b101);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (cs16) pulses16++;
    if (cs4)  pulses4++;
  end

  initial begin
    fork
      monitor(0);
      monitor(1);
    join_none
  end

  initial begin
    int   n;
    logic [7:0] bytes [4];
    bytes[0] = 8'h00; bytes[1] = 8'h55; bytes[2] = 8'hAA; bytes[3] = 8'hFF;

    // Reset with load held high: must stay idle.
    reset  = 1'b0;
    load16 = 1'b1;
    pin16  = 8'hA5;
    repeat (3) tick();
    @(negedge clk);
    chk({so16, busy16, cs16} == 3'b100, "reset_state16", int'({so16, busy16, cs16}), 3'b100);
    chk({so4, busy4, cs4} == 3'b100, "reset_state4", int'({so4, busy4, cs4}), 3'b100);

    // First edge with reset released accepts the pending load of 0xA5.
    q16.push_back('{abort: 1'b0, d: 8'hA5});
    reset = 1'b1;
    tick();
    load16 = 1'b0;
    wait_sent(0, n);
    chk(n == 161, "latency_a5", n, 161);
    repeat (5) tick();

    // 0x00 then 0xFF back to back, second load in the DONE cycle.
    q16.push_back('{abort: 1'b0, d: 8'h00});
    load16 = 1'b1;
    pin16  = 8'h00;
    tick();
    load16 = 1'b0;
    wait_sent(0, n);
    chk(n == 161, "latency_00", n, 161);
    q16.push_back('{abort: 1'b0, d: 8'hFF});
    load16 = 1'b1;
    pin16  = 8'hFF;
    tick();
    load16 = 1'b0;
    @(negedge clk);
    chk({so16, busy16} == 2'b01, "b2b_start", int'({so16, busy16}), 2'b01);
    wait_sent(0, n);
    chk(n == 160, "latency_ff", n, 160);
    repeat (3) tick();

    // Load at cycle 40 with new data must be ignored.
    q16.push_back('{abort: 1'b0, d: 8'hC3});
    load16 = 1'b1;
    pin16  = 8'hC3;
    tick();
    load16 = 1'b0;
    repeat (39) tick();
    load16 = 1'b1;
    pin16  = 8'h3C;
    tick();
    load16 = 1'b0;
    pin16  = 8'h00;
    wait_sent(0, n);
    chk(n == 121, "ignored_load_end", n, 121);
    repeat (20) @(negedge clk);
    chk({so16, busy16} == 2'b10, "no_requeue", int'({so16, busy16}), 2'b10);

    // Reset at cycle 70 of a 0x81 frame, then a clean 0x81 frame.
    q16.push_back('{abort: 1'b1, d: 8'h81});
    load16 = 1'b1;
    pin16  = 8'h81;
    tick();
    load16 = 1'b0;
    repeat (69) tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    chk({so16, busy16, cs16} == 3'b100, "abort_idle", int'({so16, busy16, cs16}), 3'b100);
    reset = 1'b1;
    repeat (3) tick();
    q16.push_back('{abort: 1'b0, d: 8'h81});
    load16 = 1'b1;
    tick();
    load16 = 1'b0;
    wait_sent(0, n);
    chk(n == 161, "latency_81", n, 161);

    // Receiver-style loopback patterns.
    for (int i = 0; i < 4; i++) begin
      repeat (2) tick();
      q16.push_back('{abort: 1'b0, d: bytes[i]});
      load16 = 1'b1;
      pin16  = bytes[i];
      tick();
      load16 = 1'b0;
      wait_sent(0, n);
      chk(n == 161, "latency_loop", n, 161);
    end

    // Short-bit build: 0x5A, 40-cycle frame.
    q4.push_back('{abort: 1'b0, d: 8'h5A});
    load4 = 1'b1;
    pin4  = 8'h5A;
    tick();
    load4 = 1'b0;
    wait_sent(1, n);
    chk(n == 41, "latency_spb4", n, 41);

    repeat (5) tick();
    chk(pulses16 == 9, "pulse_count16", pulses16, 9);
    chk(pulses4 == 1, "pulse_count4", pulses4, 1);
    chk(q16.size() == 0, "queue16_empty", q16.size(), 0);
    chk(q4.size() == 0, "queue4_empty", q4.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
